// File: rtl/multu_hilo_pkg.sv
//------------------------------------------------------------------------------
// multu_hilo_pkg : shared FSM encoding, default width and MIPS funct codes
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multu_hilo_pkg;

    localparam int unsigned c_default_width = 32;

    // funct field values of the instructions that drive this unit
    localparam logic [5:0] c_funct_multu = 6'd25;
    localparam logic [5:0] c_funct_mfhi  = 6'd16;
    localparam logic [5:0] c_funct_mflo  = 6'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : multu_hilo_pkg

`default_nettype wire

// File: rtl/multu_hilo.sv
//------------------------------------------------------------------------------
// multu_hilo : fixed-latency shift-add unsigned multiplier with HI/LO registers
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned c_pw    = 2 * WIDTH;
    localparam int unsigned c_cnt_w = $clog2(ITER + 1);

    state_e               state_q, state_d;
    logic [c_pw-1:0]      mcand_q, mcand_d;
    logic [c_pw-1:0]      acc_q,   acc_d;
    logic [WIDTH-1:0]     mplr_q,  mplr_d;
    logic [WIDTH-1:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]     lo_q,    lo_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic                 done_q,  done_d;

    logic                 w_last;
    logic [c_pw-1:0]      w_sum;

    assign w_last = (cnt_q == c_cnt_w'(ITER - 1));
    // carry out of the product-width add is dropped: an unsigned product always fits
    assign w_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)  state_d = ST_MUL;
            ST_MUL:  if (w_last) state_d = ST_DONE;
            ST_DONE:             state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        stall = rd_req && busy;
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
    end

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, op_a};
                    mplr_d  = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                acc_d   = w_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + c_cnt_w'(1);
                // HI/LO only change once the whole product is ready
                if (w_last) begin
                    {hi_d, lo_d} = w_sum;
                    done_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule : multu_hilo

`default_nettype wire

// File: tb/tb_multu_hilo.sv
//------------------------------------------------------------------------------
// tb_multu_hilo : randomized self-checking bench for multu_hilo
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        rd_req;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multu_hilo #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_req (rd_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Issues one multiply; returns the cycle index of the done pulse (1 = first
    // cycle after the accepting edge), busy/stall cycle counts, whether HI/LO
    // moved before done, and the time of the done cycle. Ends just after the
    // edge that leaves DONE. An optional second start is driven at cycle inj_at.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output int busy_n, output int stall_n,
                          output bit mid_chg, output time t_done);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_n = 0; stall_n = 0; mid_chg = 1'b0; t_done = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == inj_at) begin
                start = 1'b1; op_a = ia; op_b = ib;
            end else if (i == inj_at + 1) begin
                start = 1'b0;
            end
            if (busy)  busy_n++;
            if (stall) stall_n++;
            if (!done && (hi !== h0 || lo !== l0)) mid_chg = 1'b1;
            if (done) begin
                lat = i; t_done = $time;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_a = 32'd7; op_b = 32'd9; rd_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        start = 1'b0; rd_req = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            n_err++; $display("FAIL idle_hold: busy %b hilo %h want 0/0", busy, {hi, lo});
        end
    endtask

    task automatic test_basic();
        int lat, bn, sn; bit mc; time td;
        run_op(32'd3, 32'd5, -5, 0, 0, lat, bn, sn, mc, td);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d want 33", lat); end
        n_vec++; if (bn !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", bn); end
        n_vec++; if (mc !== 1'b0) begin n_err++; $display("FAIL basic_partial_visible: got %b want 0", mc); end
        n_vec++; if ({hi, lo} !== 64'd15) begin n_err++; $display("FAIL basic_product: got %h want %h", {hi, lo}, 64'd15); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL basic_after: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_max();
        int lat, bn, sn; bit mc; time td;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -5, 0, 0, lat, bn, sn, mc, td);
        n_vec++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL max_hi: got %h want fffffffe", hi); end
        n_vec++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL max_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_zero();
        int lat, bn, sn; bit mc; time td;
        run_op(32'h1234_5678, 32'd0, -5, 0, 0, lat, bn, sn, mc, td);
        n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL zero_product: got %h want 0", {hi, lo}); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL zero_latency: got %0d want 33", lat); end
    endtask

    task automatic test_ignore_start();
        int lat, bn, sn; bit mc; time td;
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom; b = $urandom;
        exp = 64'(a) * 64'(b);
        run_op(a, b, 10, ~a, b ^ 32'h5A5A_5A5A, lat, bn, sn, mc, td);
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL ignore_product: got %h want %h", {hi, lo}, exp); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        repeat (40) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart: busy %b want 0", busy); end
    endtask

    task automatic test_stall();
        int lat, bn, sn; bit mc; time td;
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom; b = $urandom;
        exp = 64'(a) * 64'(b);
        rd_req = 1'b1;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b want 0", stall); end
        @(posedge clk); #1;
        run_op(a, b, -5, 0, 0, lat, bn, sn, mc, td);
        n_vec++; if (sn !== 33) begin n_err++; $display("FAIL stall_cycles: got %0d want 33", sn); end
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", stall); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL stall_read: got %h want %h", {hi, lo}, exp); end
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat, bn, sn, dn; bit mc; time td;
        logic [31:0] a, b;
        logic [63:0] exp;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL abort_hilo: got %h want 0", {hi, lo}); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy || hi !== 32'd0 || lo !== 32'd0) dn++;
        end
        n_vec++; if (dn !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", dn); end
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        exp = 64'(a) * 64'(b);
        run_op(a, b, -5, 0, 0, lat, bn, sn, mc, td);
        n_vec++; if ({hi, lo} !== exp || lat !== 33) begin
            n_err++; $display("FAIL abort_restart: got %h lat %0d want %h lat 33", {hi, lo}, lat, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn, sn; bit mc; time t0, t1;
        logic [31:0] a, b;
        logic [63:0] exp;
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            a = $urandom; b = $urandom;
            if (k == 1) a = 32'd1;
            if (k == 2) b = 32'h8000_0000;
            exp = 64'(a) * 64'(b);
            run_op(a, b, -5, 0, 0, lat, bn, sn, mc, t1);
            n_vec++; if ({hi, lo} !== exp || mc !== 1'b0) begin
                n_err++; $display("FAIL b2b_product[%0d]: a %h b %h got %h want %h", k, a, b, {hi, lo}, exp);
            end
            if (k > 0) begin
                n_vec++; if (t1 - t0 !== 340) begin
                    n_err++; $display("FAIL b2b_spacing[%0d]: got %0t want 340", k, t1 - t0);
                end
            end
            t0 = t1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; rd_req = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multu_hilo

`default_nettype wire

// File: doc/multu_hilo.md
MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter ITER, default WIDTH, number of shift-add iterations.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request from EX stage to begin an unsigned multiply (MULTU).
REQ-006 SHALL have port op_a  input  WIDTH  unsigned multiplicand (rs value).
REQ-007 SHALL have port op_b  input  WIDTH  unsigned multiplier (rt value).
REQ-008 SHALL have port rd_req  input  1  EX stage holds MFHI or MFLO this cycle.
REQ-009 SHALL have port busy  output  1  multiply in progress (state not IDLE).
REQ-010 SHALL have port stall  output  1  freeze request to pipeline: rd_req AND busy, combinational.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse, registered.
REQ-012 SHALL have port hi  output  WIDTH  HI register, upper product half.
REQ-013 SHALL have port lo  output  WIDTH  LO register, lower product half.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 IDLE: start=1 at edge E0 SHALL latch op_a zero-extended to 2*WIDTH, latch op_b, clear accumulator and counter, go to MUL.
REQ-016 IDLE: start=0 SHALL hold state; hi/lo unchanged.
REQ-017 MUL: each edge SHALL add shifted multiplicand to the 2*WIDTH accumulator if multiplier bit0=1, then shift multiplicand left 1, multiplier right 1, and increment counter.
REQ-018 Accumulator add SHALL be 2*WIDTH bits, carry out discarded (unsigned product cannot exceed 2*WIDTH bits).
REQ-019 Latency SHALL be fixed: ITER iterations on edges E1..E32 regardless of operand values; no early termination.
REQ-020 At the final iteration edge (E32), {hi,lo} SHALL load the full product and the FSM SHALL go to DONE.
REQ-021 hi/lo SHALL keep previous values throughout MUL; no partial products visible.
REQ-022 DONE: done=1 for exactly that cycle; next edge (E33) SHALL return to IDLE.
REQ-023 busy SHALL be 1 in MUL and DONE, 0 in IDLE.
REQ-024 start while busy=1 SHALL be ignored; operands and progress unaffected.
REQ-025 start in the IDLE cycle immediately after DONE SHALL be accepted normally (back-to-back throughput: one multiply per 34 cycles).
REQ-026 rd_req with busy=0 SHALL give stall=0; hi/lo read directly, the same cycle.
REQ-027 rd_req and done in the same cycle SHALL give stall=1, since busy=1 in DONE; the reader sees the new hi/lo once in IDLE.
REQ-028 Counter SHALL be wide enough for ITER and SHALL not wrap within one operation.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, hi=0, lo=0, done=0, counter=0, accumulator=0, taking priority over start.
REQ-030 rst during MUL or DONE SHALL abort the operation; no hi/lo update and no done pulse afterwards.
REQ-031 Outputs SHALL be the reset values from the first edge with rst=1 until start is accepted after rst deasserts.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE/MUL/DONE, 2 bits), the WIDTH default and the MULTU/MFHI/MFLO funct codes (25, 16, 18).
REQ-033 The block SHALL be a single module with counter and datapath inline; no sub-module.
REQ-034 The block SHALL contain no latches; every register is reset per REQ-029.

Verification
REQ-035 Test: start, a=3, b=5 -> done at E33 cycle; hi=0, lo=15; busy high for 33 cycles.
REQ-036 Test: a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 Test: a=0x12345678, b=0 after a prior result -> hi=0, lo=0, latency still 33 cycles.
REQ-038 Test: second start pulse at E10 with different operands -> ignored; first product delivered unchanged at E33.
REQ-039 Test: rd_req held from E5 to E40 -> stall=1 exactly while busy, 0 afterwards; hi/lo updated before stall drops.
REQ-040 Test: rst asserted at E20 -> hi=lo=0, no done pulse, busy=0 next cycle; a new start then completes correctly.
